// File: rtl/serial_sub_engine.sv
// Bit-serial subtractor computing a - b - bin one bit per clock, LSB first.
// The low APPROX_BITS positions use a runtime-selectable exact/approximate cell.
module serial_sub_engine #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_mode;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_x;
  logic w_y;
  logic w_t;
  logic w_in_approx;
  logic w_d;
  logic w_bo;
  logic w_last;

  assign w_x         = r_a[r_cnt];
  assign w_y         = r_b[r_cnt];
  assign w_t         = w_x ^ w_y;
  assign w_in_approx = (int'(r_cnt) < APPROX_BITS);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  // Cell for the current bit; reserved mode 3 falls back to the exact cell.
  always_comb begin
    w_d  = w_t ^ r_borrow;
    w_bo = w_t ? w_y : r_borrow;
    if (w_in_approx) begin
      case (r_mode)
        2'd1:    w_d  = w_t | r_borrow;
        2'd2:    w_bo = w_t ^ r_borrow;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 2'd0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_mode     <= mode;
            r_borrow   <= bin;
            r_cnt      <= '0;
            r_diff     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_diff[r_cnt] <= w_d;
          r_borrow      <= w_bo;
          r_cnt         <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout      <= w_bo;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result holds until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_sub_engine.sv
// Self-checking bench for serial_sub_engine: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_serial_sub_engine;

  localparam int WIDTH       = 8;
  localparam int APPROX_BITS = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  int checkCount;
  int passCount;

  serial_sub_engine #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(APPROX_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact modes use plain two's-complement arithmetic; approximate
  // modes apply the cell rules on the low bits, then arithmetic on the rest.
  function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] ra,
                                              input logic [WIDTH-1:0] rb,
                                              input logic rbin,
                                              input logic [1:0] rmode);
    logic [WIDTH-1:0] d;
    logic             c;
    logic             t;
    int               hi;
    if (rmode == 2'd0 || rmode == 2'd3)
      return {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
    d = '0;
    c = rbin;
    for (int i = 0; i < APPROX_BITS; i++) begin
      t = ra[i] ^ rb[i];
      if (rmode == 2'd1) begin
        d[i] = t | c;
        c    = t ? rb[i] : c;
      end else begin
        d[i] = t ^ c;
        c    = d[i];
      end
    end
    hi = int'(ra >> APPROX_BITS) - int'(rb >> APPROX_BITS) - int'(c);
    d  = d | (WIDTH'(hi) << APPROX_BITS);
    return {(hi < 0), d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full operation: accept, run with noise on in_valid/out_ready, hold
  // the result for readyDelay cycles, then complete the output handshake.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] sa,
                               input logic [WIDTH-1:0] sb, input logic sbin,
                               input logic [1:0] smode, input int readyDelay,
                               input bit noisy);
    logic [WIDTH:0] expected;
    int             edges;
    bit             timedOut;
    expected = refModel(sa, sb, sbin, smode);
    checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a        = sa;
    b        = sb;
    bin      = sbin;
    mode     = smode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    bin      = 1'($urandom);
    mode     = 2'($urandom);
    edges    = 1;
    timedOut = 1'b0;
    while (!out_valid) begin
      if (edges > 4 * WIDTH) begin
        timedOut = 1'b1;
        break;
      end
      if (noisy) begin
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
      end
      tick();
      edges++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, " timeout"}, 32'(timedOut), 32'd0);
    if (timedOut) begin
      doReset();
      return;
    end
    checkOutput({tag, " latency"}, 32'(edges), 32'(WIDTH + 1));
    for (int k = 0; k < readyDelay; k++) tick();
    checkOutput({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " out_valid held"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " diff"}, 32'(diff), 32'(expected[WIDTH-1:0]));
    checkOutput({tag, " bout"}, 32'(bout), 32'(expected[WIDTH]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready restored"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit sawValid;
    checkCount = 0;
    passCount  = 0;
    a    = '0;
    b    = '0;
    bin  = 1'b0;
    mode = 2'd0;

    doReset();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset diff", 32'(diff), 32'd0);
    checkOutput("reset bout", 32'(bout), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    // Reset in the middle of a run aborts the operation.
    a        = 8'hFF;
    b        = 8'h01;
    bin      = 1'b1;
    mode     = 2'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("busy mid-run", 32'(busy), 32'd1);
    doReset();
    checkOutput("midrun reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrun reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrun reset diff", 32'(diff), 32'd0);
    checkOutput("midrun reset bout", 32'(bout), 32'd0);
    sawValid = 1'b0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      tick();
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("no out_valid after abort", 32'(sawValid), 32'd0);

    applyStimulus("exact 5A-3C", 8'h5A, 8'h3C, 1'b0, 2'd0, 0, 1'b0);
    applyStimulus("exact 00-01", 8'h00, 8'h01, 1'b0, 2'd0, 0, 1'b0);
    applyStimulus("exact bin", 8'h10, 8'h0F, 1'b1, 2'd3, 0, 1'b0);
    applyStimulus("approx1 02-01", 8'h02, 8'h01, 1'b0, 2'd1, 0, 1'b0);
    applyStimulus("approx2 01-00", 8'h01, 8'h00, 1'b0, 2'd2, 0, 1'b0);
    checkOutput("approx1 known diff", 32'(refModel(8'h02, 8'h01, 1'b0, 2'd1)), 32'h003);
    checkOutput("approx2 known diff", 32'(refModel(8'h01, 8'h00, 1'b0, 2'd2)), 32'h1FF);
    applyStimulus("backpressure", 8'hC3, 8'h5D, 1'b1, 2'd0, 5, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      applyStimulus("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                    2'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
